// File: rtl/tcdm_interconnect_pkg.sv
// Shared types for the TCDM interconnect port controllers.
package tcdm_interconnect_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } credit_state_e;

endpackage

// File: rtl/variable_latency_credit_ctrl.sv
// Credit gate between an initiator and a variable-latency interconnect port:
// bounds requests in flight and supports a flush/quiesce handshake.
module variable_latency_credit_ctrl
  import tcdm_interconnect_pkg::*;
#(
  parameter int unsigned NumOutstanding = 8,
  parameter int unsigned ReqWidth       = 70,
  parameter int unsigned RspWidth       = 33
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  output logic                                  flush_done_o,
  output logic                                  err_o,
  output logic [$clog2(NumOutstanding+1)-1:0]   outstanding_o,
  input  logic                                  ini_req_valid_i,
  output logic                                  ini_req_ready_o,
  input  logic [ReqWidth-1:0]                   ini_req_data_i,
  output logic                                  ini_resp_valid_o,
  input  logic                                  ini_resp_ready_i,
  output logic [RspWidth-1:0]                   ini_resp_data_o,
  output logic                                  xbar_req_valid_o,
  input  logic                                  xbar_req_ready_i,
  output logic [ReqWidth-1:0]                   xbar_req_data_o,
  input  logic                                  xbar_resp_valid_i,
  output logic                                  xbar_resp_ready_o,
  input  logic [RspWidth-1:0]                   xbar_resp_data_i
);

  localparam int unsigned CntW = $clog2(NumOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(NumOutstanding);

  credit_state_e   state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q, err_d;
  logic            flush_done_q;
  logic            gate;
  logic            req_hs, rsp_hs, req_stall;

  // Payload and response path are pure wires.
  assign xbar_req_data_o   = ini_req_data_i;
  assign ini_resp_valid_o  = xbar_resp_valid_i;
  assign ini_resp_data_o   = xbar_resp_data_i;
  assign xbar_resp_ready_o = ini_resp_ready_i;

  assign req_hs    = xbar_req_valid_o & xbar_req_ready_i;
  assign rsp_hs    = xbar_resp_valid_i & xbar_resp_ready_o;
  assign req_stall = xbar_req_valid_o & ~xbar_req_ready_i;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; RUN waits out a stalled request so it is counted before draining.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush_i && !req_stall) state_d = DRAIN;
      DRAIN:   if (count_d == '0) state_d = HALT;
      HALT:    if (!flush_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Request gating; gate cannot fall mid-stall since count only moves on a handshake.
  always_comb begin
    gate             = (state_q == RUN) && (count_q < MaxCnt);
    xbar_req_valid_o = ini_req_valid_i & gate;
    ini_req_ready_o  = xbar_req_ready_i & gate;
  end

  // Credit count; an unexpected response flags an error instead of wrapping.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    unique case ({req_hs, rsp_hs})
      2'b10: count_d = count_q + CntW'(1);
      2'b01: begin
        if (count_q == '0) err_d = 1'b1;
        else               count_d = count_q - CntW'(1);
      end
      2'b11: if (count_q == '0) err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q      <= '0;
      err_q        <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      err_q        <= err_d;
      flush_done_q <= (state_d == HALT);
    end
  end

  assign outstanding_o = count_q;
  assign flush_done_o  = flush_done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_variable_latency_credit_ctrl.sv
// Randomized + directed bench for variable_latency_credit_ctrl with a
// cycle-level reference model feeding a scoreboard.
module tb_variable_latency_credit_ctrl;

  localparam int unsigned NO   = 4;
  localparam int unsigned ReqW = 70;
  localparam int unsigned RspW = 33;
  localparam int unsigned CW   = $clog2(NO + 1);

  localparam int S_RUN = 0, S_DRAIN = 1, S_HALT = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            flush_i = 1'b0;
  logic            flush_done_o, err_o;
  logic [CW-1:0]   outstanding_o;
  logic            ini_req_valid_i = 1'b0;
  logic            ini_req_ready_o;
  logic [ReqW-1:0] ini_req_data_i = '0;
  logic            ini_resp_valid_o;
  logic            ini_resp_ready_i = 1'b0;
  logic [RspW-1:0] ini_resp_data_o;
  logic            xbar_req_valid_o;
  logic            xbar_req_ready_i = 1'b0;
  logic [ReqW-1:0] xbar_req_data_o;
  logic            xbar_resp_valid_i = 1'b0;
  logic            xbar_resp_ready_o;
  logic [RspW-1:0] xbar_resp_data_i = '0;

  variable_latency_credit_ctrl #(
    .NumOutstanding(NO), .ReqWidth(ReqW), .RspWidth(RspW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .flush_done_o(flush_done_o), .err_o(err_o), .outstanding_o(outstanding_o),
    .ini_req_valid_i(ini_req_valid_i), .ini_req_ready_o(ini_req_ready_o),
    .ini_req_data_i(ini_req_data_i),
    .ini_resp_valid_o(ini_resp_valid_o), .ini_resp_ready_i(ini_resp_ready_i),
    .ini_resp_data_o(ini_resp_data_o),
    .xbar_req_valid_o(xbar_req_valid_o), .xbar_req_ready_i(xbar_req_ready_i),
    .xbar_req_data_o(xbar_req_data_o),
    .xbar_resp_valid_i(xbar_resp_valid_i), .xbar_resp_ready_o(xbar_resp_ready_o),
    .xbar_resp_data_i(xbar_resp_data_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit xv, ir, rv, rr, fd, err;
    int cnt;
  } exp_t;

  exp_t            exp_q[$];
  logic [ReqW-1:0] req_q[$];
  logic [RspW-1:0] rsp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the port as seen from outside, in plain integers.
  int              m_state = S_RUN;
  int              m_count = 0;
  bit              m_err   = 1'b0;
  bit              pend    = 1'b0;
  logic [ReqW-1:0] pend_data = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ReqW-1:0] rand_req();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[ReqW-1:0];
  endfunction

  function automatic logic [RspW-1:0] rand_rsp();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[RspW-1:0];
  endfunction

  // One clock of stimulus; predicts this cycle's outputs and the next state.
  task automatic cycle(input bit rst_v, input bit flush_v, input bit iv,
                       input bit xr, input bit rv, input bit rr);
    bit gate, xv, ir, req, rsp, stall;
    int n;
    @(negedge clk_i);
    rst_ni = rst_v;
    flush_i = flush_v;
    if (!rst_v) begin
      pend = 1'b0;
      m_state = S_RUN;
      m_count = 0;
      m_err = 1'b0;
    end
    if (pend) begin
      ini_req_valid_i = 1'b1;
      ini_req_data_i  = pend_data;
    end else begin
      ini_req_valid_i = iv && rst_v;
      ini_req_data_i  = rand_req();
    end
    xbar_req_ready_i  = xr;
    xbar_resp_valid_i = rv && rst_v;
    xbar_resp_data_i  = rand_rsp();
    ini_resp_ready_i  = rr;

    gate = (m_state == S_RUN) && (m_count < int'(NO));
    xv   = ini_req_valid_i && gate;
    ir   = xr && gate;
    exp_q.push_back('{xv: xv, ir: ir, rv: xbar_resp_valid_i, rr: rr,
                      fd: (m_state == S_HALT), err: m_err, cnt: m_count});
    req   = xv && xr;
    rsp   = xbar_resp_valid_i && rr;
    stall = xv && !xr;
    if (req) req_q.push_back(ini_req_data_i);
    if (xbar_resp_valid_i) rsp_q.push_back(xbar_resp_data_i);
    pend      = rst_v && ini_req_valid_i && !ir;
    pend_data = ini_req_data_i;

    if (rst_v) begin
      if (rsp && m_count == 0) m_err = 1'b1;
      n = m_count + (req ? 1 : 0) - (rsp ? 1 : 0);
      if (n < 0) n = 0;
      case (m_state)
        S_RUN:   if (flush_v && !stall) m_state = S_DRAIN;
        S_DRAIN: if (n == 0) m_state = S_HALT;
        default: if (!flush_v) m_state = S_RUN;
      endcase
      m_count = n;
    end
  endtask

  // Monitor: compares every cycle's outputs, pops payloads on handshakes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("xbar_req_valid", 128'(xbar_req_valid_o), 128'(e.xv));
        chk("ini_req_ready", 128'(ini_req_ready_o), 128'(e.ir));
        chk("ini_resp_valid", 128'(ini_resp_valid_o), 128'(e.rv));
        chk("xbar_resp_ready", 128'(xbar_resp_ready_o), 128'(e.rr));
        chk("outstanding", 128'(outstanding_o), 128'(e.cnt));
        chk("flush_done", 128'(flush_done_o), 128'(e.fd));
        chk("err", 128'(err_o), 128'(e.err));
      end
      if (xbar_req_valid_o && xbar_req_ready_i) begin
        if (req_q.size() == 0) chk("unexpected_req_hs", 128'(1), 128'(0));
        else chk("xbar_req_data", 128'(xbar_req_data_o), 128'(req_q.pop_front()));
      end
      if (ini_resp_valid_o) begin
        if (rsp_q.size() == 0) chk("unexpected_resp", 128'(1), 128'(0));
        else chk("ini_resp_data", 128'(ini_resp_data_o), 128'(rsp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    bit fl;
    // Saturation at NO credits and admission after a response.
    do_reset();
    settle();
    chk("reset_outstanding", 128'(outstanding_o), 128'(0));
    chk("reset_flush_done", 128'(flush_done_o), 128'(0));
    chk("reset_err", 128'(err_o), 128'(0));
    repeat (6) cycle(1, 0, 1, 1, 0, 0);
    settle();
    chk("sat_outstanding", 128'(outstanding_o), 128'(4));
    chk("sat_ini_ready", 128'(ini_req_ready_o), 128'(0));
    cycle(1, 0, 1, 1, 1, 1);
    settle();
    chk("sat_rsp_cycle_ready", 128'(ini_req_ready_o), 128'(0));
    cycle(1, 0, 1, 1, 0, 0);
    settle();
    chk("sat_admit_after_rsp", 128'(xbar_req_valid_o), 128'(1));
    cycle(1, 0, 0, 1, 0, 0);
    settle();
    chk("sat_refill", 128'(outstanding_o), 128'(4));

    // Simultaneous request and response handshakes.
    do_reset();
    repeat (2) cycle(1, 0, 1, 1, 0, 0);
    cycle(1, 0, 1, 1, 1, 1);
    cycle(1, 0, 0, 1, 0, 0);
    settle();
    chk("simul_hs_count", 128'(outstanding_o), 128'(2));

    // Flush with three in flight.
    do_reset();
    repeat (3) cycle(1, 0, 1, 1, 0, 0);
    cycle(1, 1, 0, 1, 0, 0);
    cycle(1, 1, 1, 1, 0, 0);
    settle();
    chk("drain_blocks_req", 128'(ini_req_ready_o), 128'(0));
    repeat (3) cycle(1, 1, 1, 1, 1, 1);
    cycle(1, 1, 1, 1, 0, 0);
    cycle(1, 1, 1, 1, 0, 0);
    settle();
    chk("halt_flush_done", 128'(flush_done_o), 128'(1));
    chk("halt_outstanding", 128'(outstanding_o), 128'(0));
    chk("halt_blocks_req", 128'(xbar_req_valid_o), 128'(0));
    cycle(1, 0, 1, 1, 0, 0);
    cycle(1, 0, 1, 1, 0, 0);
    settle();
    chk("resume_flush_done", 128'(flush_done_o), 128'(0));
    chk("resume_accept", 128'(xbar_req_valid_o), 128'(1));

    // Flush while a request is stalled.
    do_reset();
    repeat (2) cycle(1, 0, 1, 0, 0, 0);
    repeat (2) cycle(1, 1, 1, 0, 0, 0);
    settle();
    chk("stall_valid_held", 128'(xbar_req_valid_o), 128'(1));
    cycle(1, 1, 0, 1, 0, 0);
    cycle(1, 1, 1, 1, 0, 0);
    settle();
    chk("stall_counted", 128'(outstanding_o), 128'(1));
    chk("stall_then_drain", 128'(ini_req_ready_o), 128'(0));
    cycle(1, 1, 1, 1, 1, 1);
    repeat (3) cycle(1, 0, 1, 1, 0, 0);

    // Response with nothing in flight.
    do_reset();
    cycle(1, 0, 0, 1, 1, 1);
    cycle(1, 0, 0, 1, 0, 0);
    settle();
    chk("err_set", 128'(err_o), 128'(1));
    chk("err_count_zero", 128'(outstanding_o), 128'(0));
    repeat (3) cycle(1, 0, 1, 1, 0, 0);
    settle();
    chk("err_sticky", 128'(err_o), 128'(1));
    cycle(0, 0, 0, 0, 0, 0);
    settle();
    chk("err_reset", 128'(err_o), 128'(0));

    // Reset in the middle of a drain.
    do_reset();
    repeat (2) cycle(1, 0, 1, 1, 0, 0);
    cycle(1, 1, 0, 1, 0, 0);
    cycle(1, 1, 0, 1, 0, 0);
    settle();
    chk("mid_drain_count", 128'(outstanding_o), 128'(2));
    cycle(0, 1, 0, 1, 0, 0);
    settle();
    chk("rst_outstanding", 128'(outstanding_o), 128'(0));
    chk("rst_flush_done", 128'(flush_done_o), 128'(0));
    chk("rst_ini_ready", 128'(ini_req_ready_o), 128'(1));
    cycle(1, 0, 1, 1, 0, 0);
    settle();
    chk("post_rst_accept", 128'(xbar_req_valid_o), 128'(1));

    // Random traffic: phase 0 saturates credits, phase 1 is response-heavy.
    fl = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 2500; i++) begin
        bit rs, iv, xr, rv, rr;
        rs = ($urandom_range(0, 399) != 0);
        if ($urandom_range(0, 39) == 0) fl = !fl;
        iv = ($urandom_range(0, 2) != 0);
        xr = ($urandom_range(0, 3) != 0);
        if (m_count > 0) rv = (p == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
        else             rv = ($urandom_range(0, 59) == 0);
        rr = ($urandom_range(0, 3) != 0);
        cycle(rs, fl, iv, xr, rv, rr);
      end
    end
    cycle(1, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    #4;
    chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
    chk("req_q_drained", 128'(req_q.size()), 128'(0));
    chk("rsp_q_drained", 128'(rsp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
